if_id_buffer: RTL

- Decoupling buffer between stage_if and the decode stage in the 5-stage MIPS pipeline.
- Captures each fetched instruction and its PC+4 into a small in-order FIFO.
- Presents the oldest entry to decode and holds it there while decode is stalled.
- Drives the fetch stall while full; drops all contents on a decode-side redirect (flush).

---
 rtl/if_id_buffer.sv | 97 +++++++++
 1 files changed

// File: rtl/if_id_buffer.sv
// rtl/if_id_buffer.sv - IF/ID decoupling FIFO between fetch and decode
// Optional IF_ID_PERF_EN adds stall-cycle and flush-event counters.
module if_id_buffer #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              IR_F,
  input  logic [31:0]              PCInc4_F,
  input  logic                     valid_F,
  input  logic                     stall_D,
  input  logic                     flush_D,
  output logic [31:0]              IR_D,
  output logic [31:0]              PCInc4_D,
  output logic                     valid_D,
  output logic                     stall_F,
`ifdef IF_ID_PERF_EN
  output logic [31:0]              perf_stall_cycles,
  output logic [31:0]              perf_flush_count,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   ir_mem_q [DEPTH];
  logic [31:0]   pc_mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign stall_F = (count_q == CW'(DEPTH));
  assign valid_D = (count_q != '0);
  assign push    = valid_F & ~stall_F & ~flush_D;
  assign pop     = valid_D & ~stall_D & ~flush_D;

  assign IR_D     = valid_D ? ir_mem_q[rd_ptr_q] : NOP_WORD;
  assign PCInc4_D = valid_D ? pc_mem_q[rd_ptr_q] : 32'h0;
  assign count    = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_D) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      ir_mem_q[wr_ptr_q] <= IR_F;
      pc_mem_q[wr_ptr_q] <= PCInc4_F;
    end
  end

`ifdef IF_ID_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_F) perf_stall_q <= perf_stall_q + 32'd1;
      if (flush_D) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_count  = perf_flush_q;
`endif

endmodule
